// File: rtl/sysctrl_gen_pkg.sv
// sysctrl_gen shared definitions: command codes, status magic, id match, bit reverse.
package sysctrl_gen_pkg;

  typedef enum logic [7:0] {
    CMD_STATUS  = 8'h00,
    CMD_LED     = 8'h01,
    CMD_COLOR   = 8'h02,
    CMD_BUTTONS = 8'h03,
    CMD_VAR_WR  = 8'h04,
    CMD_IRQ     = 8'h05,
    CMD_VAR_RD  = 8'h06,
    CMD_MASK    = 8'h07
  } cmd_e;

  localparam logic [7:0] MAGIC0 = 8'h5C;
  localparam logic [7:0] MAGIC1 = 8'h42;

  // Config variables are addressed by a one-byte ASCII id.
  function automatic logic id_match(input logic [7:0] id, input logic [7:0] cand);
    return id == cand;
  endfunction

  // The MCU sends colour bytes LSB-first relative to the ws2812 shifter.
  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sysctrl_gen_if.sv
// Byte stream from the MCU SPI deframer and the registered reply byte.
interface sysctrl_gen_if;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output data_in_strobe, data_in_start, data_in, input data_out);
  modport slave  (input data_in_strobe, data_in_start, data_in, output data_out);
endinterface

// File: rtl/sysctrl_gen_irq.sv
// Interrupt block: 2-flop sync, rising-edge detect, sticky pending, mask,
// coldboot flag and the registered active-low interrupt line.
module sysctrl_gen_irq #(
  parameter int NUM_INTS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_INTS-1:0] int_in,
  input  logic                ack_vld,
  input  logic [7:0]          ack_bits,
  input  logic                mask_wr,
  input  logic [7:0]          mask_bits,
  output logic [NUM_INTS-1:0] pending,
  output logic                coldboot,
  output logic                int_out_n
);

  localparam logic [NUM_INTS-1:0] BIT0 = {{(NUM_INTS-1){1'b0}}, 1'b1};

  logic [NUM_INTS-1:0] s1, s2, s3, mask, rise, clr;

  // Channel 0 belongs to coldboot, so its source never sets pending.
  assign rise = s2 & ~s3 & ~BIT0;
  assign clr  = ack_vld ? ack_bits[NUM_INTS-1:0] : '0;

  // Sync, pending (set beats ack), mask and interrupt output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      pending   <= '0;
      mask      <= '1;
      coldboot  <= 1'b1;
      int_out_n <= 1'b0;
    end else begin
      s1        <= int_in;
      s2        <= s1;
      s3        <= s2;
      pending   <= ((pending & ~clr) | rise) & ~BIT0;
      if (mask_wr) mask <= mask_bits[NUM_INTS-1:0] | BIT0;
      if (ack_vld && ack_bits[0]) coldboot <= 1'b0;
      int_out_n <= !(coldboot || |(pending & mask));
    end
  end

endmodule

// File: rtl/sysctrl_gen.sv
// MCU system-control slave: frames the byte stream into commands driving
// LEDs, RGB colour, button readback, config variables and interrupts.
// Optional: SYSCTRL_READBACK_EN adds CMD6 config-variable readback.
module sysctrl_gen
  import sysctrl_gen_pkg::*;
#(
  parameter logic [7:0]            CORE_ID      = 8'h03,
  parameter int                    NUM_VARS     = 16,
  parameter logic [NUM_VARS*8-1:0] VAR_IDS      = "PONMLKJIHGFEDRBA",
  parameter logic [NUM_VARS*8-1:0] VAR_DEFAULTS = 128'h0F0E0D0C0B0A09080706050403020100,
  parameter int                    NUM_INTS     = 8,
  parameter int                    NUM_LEDS     = 2,
  parameter int                    NUM_BUTTONS  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sysctrl_gen_if.slave           bus,
  output logic                   int_out_n,
  input  logic [NUM_INTS-1:0]    int_in,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic [23:0]            color,
  output logic [NUM_VARS*8-1:0]  cfg,
  output logic [NUM_VARS-1:0]    cfg_wr
);

  logic [3:0]                state_q, state_d;
  logic [7:0]                cmd_q, cmd_d, eff_cmd, id_q, dout_d, irq_stat;
  logic [NUM_VARS-1:0][7:0]  cfg_q;
  logic [NUM_INTS-1:0]       pending;
  logic                      coldboot, data_byte, take;

  // data_byte: a payload byte inside a live frame; take: any byte that updates data_out.
  assign data_byte = bus.data_in_strobe && !bus.data_in_start && (state_q != 4'd0);
  assign take      = bus.data_in_strobe && (bus.data_in_start || (state_q != 4'd0));
  assign eff_cmd   = bus.data_in_start ? bus.data_in : cmd_q;
  assign irq_stat  = 8'(pending) | {7'b0, coldboot};
  assign cfg       = cfg_q;

`ifdef SYSCTRL_READBACK_EN
  function automatic logic [7:0] var_lookup(input logic [7:0] id,
                                            input logic [NUM_VARS-1:0][7:0] tbl);
    logic [7:0] r;
    r = 8'hFF;
    for (int i = 0; i < NUM_VARS; i++)
      if (id_match(id, VAR_IDS[8*i +: 8])) r = tbl[i];
    return r;
  endfunction
`endif

  // Frame position and command register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= 4'd0;
      cmd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next frame position: start restarts at 1 (aborting any frame), payload saturates at 15.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    if (bus.data_in_strobe && bus.data_in_start) begin
      state_d = 4'd1;
      cmd_d   = bus.data_in;
    end else if (data_byte) begin
      state_d = (state_q == 4'hF) ? state_q : state_q + 4'd1;
    end
  end

  // Reply byte: status is indexed by the position the frame moves to.
  always_comb begin
    dout_d = 8'h00;
    case (eff_cmd)
      CMD_STATUS:
        case (state_d)
          4'd1:    dout_d = MAGIC0;
          4'd2:    dout_d = MAGIC1;
          4'd3:    dout_d = CORE_ID;
          default: dout_d = 8'h00;
        endcase
      CMD_BUTTONS: dout_d = 8'(buttons);
      CMD_IRQ:     dout_d = irq_stat;
`ifdef SYSCTRL_READBACK_EN
      CMD_VAR_RD:
        if (data_byte) dout_d = var_lookup((state_q == 4'd1) ? bus.data_in : id_q, cfg_q);
`endif
      default: dout_d = 8'h00;
    endcase
  end

  // Payload writes are keyed on the position the byte arrived at.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.data_out <= 8'h00;
      leds         <= '0;
      color        <= 24'h0;
      cfg_q        <= VAR_DEFAULTS;
      cfg_wr       <= '0;
      id_q         <= 8'h00;
    end else begin
      cfg_wr <= '0;
      if (take) bus.data_out <= dout_d;
      if (data_byte) begin
        case (cmd_q)
          CMD_LED:
            if (state_q == 4'd1) leds <= bus.data_in[NUM_LEDS-1:0];
          CMD_COLOR:
            case (state_q)
              4'd1:    color[15:8]  <= bitrev8(bus.data_in);
              4'd2:    color[7:0]   <= bitrev8(bus.data_in);
              4'd3:    color[23:16] <= bitrev8(bus.data_in);
              default: ;
            endcase
          CMD_VAR_WR: begin
            if (state_q == 4'd1) id_q <= bus.data_in;
            if (state_q == 4'd2)
              for (int i = 0; i < NUM_VARS; i++)
                if (id_match(id_q, VAR_IDS[8*i +: 8])) begin
                  cfg_q[i]  <= bus.data_in;
                  cfg_wr[i] <= 1'b1;
                end
          end
`ifdef SYSCTRL_READBACK_EN
          CMD_VAR_RD:
            if (state_q == 4'd1) id_q <= bus.data_in;
`endif
          default: ;
        endcase
      end
    end
  end

  sysctrl_gen_irq #(.NUM_INTS(NUM_INTS)) u_irq (
    .clk       (clk),
    .reset_n   (reset_n),
    .int_in    (int_in),
    .ack_vld   (data_byte && (cmd_q == CMD_IRQ) && (state_q == 4'd1)),
    .ack_bits  (bus.data_in),
    .mask_wr   (data_byte && (cmd_q == CMD_MASK) && (state_q == 4'd1)),
    .mask_bits (bus.data_in),
    .pending   (pending),
    .coldboot  (coldboot),
    .int_out_n (int_out_n)
  );

endmodule
